// File: rtl/program_loader_pkg.sv
// Processor-wide constants and the boot loader state encoding.
package program_loader_pkg;
   localparam int IMEM_ADDR_W = 8;
   localparam int INSTR_W     = 16;

   typedef enum logic [2:0] {
      IDLE,
      COUNT,
      HI,
      LO,
      WRITE,
      CHK,
      DONE
   } loader_state_t;
endpackage

// File: rtl/program_loader.sv
// Boot loader: assembles a COUNT/data/CHK byte stream into 16-bit instruction
// words, writes them to instruction memory and holds the core until finished.
module program_loader
   import program_loader_pkg::*;
#(
   parameter logic [IMEM_ADDR_W-1:0] BASE_ADDR = 8'h00
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [7:0]             rx_data,
   input  logic                   rx_valid,
   output logic                   rx_ready,
   output logic                   imem_we,
   output logic [IMEM_ADDR_W-1:0] imem_addr,
   output logic [INSTR_W-1:0]     imem_wdata,
   output logic                   cpu_hold,
   output logic                   busy,
   output logic                   done,
   output logic                   error
);

   loader_state_t          r_state;
   logic [8:0]             r_rem;
   logic [IMEM_ADDR_W-1:0] r_idx;
   logic [7:0]             r_sum;
   logic [7:0]             r_hi;
   logic                   r_we;
   logic [IMEM_ADDR_W-1:0] r_addr;
   logic [INSTR_W-1:0]     r_wdata;
   logic                   r_busy;
   logic                   r_done;
   logic                   r_err;

   logic                   w_rx_ready;
   logic                   w_xfer;

   assign w_rx_ready = (r_state == COUNT) || (r_state == HI) ||
                       (r_state == LO)    || (r_state == CHK);
   assign w_xfer     = rx_valid && w_rx_ready;

   // The write strobe is raised on the low-byte handshake so that it is a
   // registered output that is high exactly while the FSM sits in WRITE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_rem   <= '0;
         r_idx   <= '0;
         r_sum   <= '0;
         r_hi    <= '0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_we   <= 1'b0;
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state <= COUNT;
                  r_busy  <= 1'b1;
                  r_err   <= 1'b0;
               end
            end
            COUNT: begin
               if (w_xfer) begin
                  // A count byte of zero encodes a full 256-word image.
                  r_rem   <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                  r_sum   <= rx_data;
                  r_idx   <= '0;
                  r_state <= HI;
               end
            end
            HI: begin
               if (w_xfer) begin
                  r_hi    <= rx_data;
                  r_sum   <= r_sum + rx_data;
                  r_state <= LO;
               end
            end
            LO: begin
               if (w_xfer) begin
                  r_sum   <= r_sum + rx_data;
                  r_wdata <= {r_hi, rx_data};
                  r_addr  <= BASE_ADDR + r_idx;
                  r_we    <= 1'b1;
                  r_state <= WRITE;
               end
            end
            WRITE: begin
               r_idx   <= r_idx + 8'd1;
               r_rem   <= r_rem - 9'd1;
               r_state <= (r_rem == 9'd1) ? CHK : HI;
            end
            CHK: begin
               if (w_xfer) begin
                  r_err   <= (rx_data != r_sum);
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end
            end
            DONE: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign rx_ready   = w_rx_ready;
   assign imem_we    = r_we;
   assign imem_addr  = r_addr;
   assign imem_wdata = r_wdata;
   assign busy       = r_busy;
   assign cpu_hold   = r_busy;
   assign done       = r_done;
   assign error      = r_err;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: two instances (base 00 and base FE) share
// stimulus; a write scoreboard per instance checks every imem_we cycle.
module tb_program_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  rx_data;
   logic        rx_valid;

   logic        rx_ready_a, we_a, hold_a, busy_a, done_a, err_a;
   logic [7:0]  addr_a;
   logic [15:0] wdata_a;
   logic        rx_ready_b, we_b, hold_b, busy_b, done_b, err_b;
   logic [7:0]  addr_b;
   logic [15:0] wdata_b;

   logic [23:0] qa[$];
   logic [23:0] qb[$];
   logic [7:0]  bq[$];

   int n_checks = 0;
   int n_pass   = 0;
   int hold_cycles = 0;
   int we_cycles   = 0;
   int h0, w0;
   logic [7:0] sum;

   program_loader #(.BASE_ADDR(8'h00)) dut_a (
      .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready_a), .imem_we(we_a), .imem_addr(addr_a), .imem_wdata(wdata_a),
      .cpu_hold(hold_a), .busy(busy_a), .done(done_a), .error(err_a)
   );

   program_loader #(.BASE_ADDR(8'hFE)) dut_b (
      .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready_b), .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wdata_b),
      .cpu_hold(hold_b), .busy(busy_b), .done(done_b), .error(err_b)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
   endtask

   task automatic push_word(input logic [7:0] idx, input logic [15:0] w);
      logic [7:0] ab;
      ab = idx + 8'hFE;
      qa.push_back({idx, w});
      qb.push_back({ab, w});
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_q(input int gap);
      int t;
      for (int i = 0; i < bq.size(); i++) begin
         rx_data  = bq[i];
         rx_valid = 1'b1;
         t = 0;
         while (!rx_ready_a && t < 100) begin
            @(negedge clk);
            t++;
         end
         if (t >= 100) check("rx_ready_timeout", 32'(rx_ready_a), 1);
         @(negedge clk);
         if (gap > 0 && i < bq.size() - 1) begin
            rx_valid = 1'b0;
            repeat (gap) @(negedge clk);
         end
      end
      rx_valid = 1'b0;
   endtask

   task automatic wait_done(input logic exp_err);
      int t;
      t = 0;
      while (!done_a && t < 3000) begin
         @(negedge clk);
         t++;
      end
      check("done_a", 32'(done_a), 1);
      check("done_b", 32'(done_b), 1);
      check("error_a", 32'(err_a), 32'(exp_err));
      check("error_b", 32'(err_b), 32'(exp_err));
      @(negedge clk);
      check("done_pulse", 32'(done_a), 0);
      check("busy_after", 32'(busy_a), 0);
      check("error_stable", 32'(err_a), 32'(exp_err));
      check("writes_drained_a", 32'(qa.size()), 0);
      check("writes_drained_b", 32'(qb.size()), 0);
   endtask

   always @(negedge clk) begin
      if (hold_a) hold_cycles++;
      if (we_a) we_cycles++;
   end

   always @(negedge clk) begin
      if (we_a) begin
         check("we_with_rx_ready", 32'(rx_ready_a), 0);
         check("write_expected_a", 32'(qa.size() > 0), 1);
         if (qa.size() > 0) check("write_a", {8'h00, addr_a, wdata_a}, {8'h00, qa.pop_front()});
      end
      if (we_b) begin
         check("write_expected_b", 32'(qb.size() > 0), 1);
         if (qb.size() > 0) check("write_b", {8'h00, addr_b, wdata_b}, {8'h00, qb.pop_front()});
      end
   end

   initial begin
      rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      repeat (2) @(negedge clk);
      check("rst_rx_ready", 32'(rx_ready_a), 0);
      check("rst_we", 32'(we_a), 0);
      check("rst_hold", 32'(hold_a), 0);
      check("rst_busy", 32'(busy_a), 0);
      check("rst_done", 32'(done_a), 0);
      check("rst_error", 32'(err_a), 0);
      check("rst_addr", 32'(addr_a), 0);
      check("rst_wdata", 32'(wdata_a), 0);
      rst = 1'b0;
      @(negedge clk);

      // Single word, rx_valid held high
      h0 = hold_cycles; w0 = we_cycles;
      push_word(8'd0, 16'h1234);
      pulse_start();
      check("t1_busy", 32'(busy_a), 1);
      check("t1_hold", 32'(hold_a), 1);
      bq = '{8'h01, 8'h12, 8'h34, 8'h47};
      send_q(0);
      wait_done(1'b0);
      check("t1_hold_cycles", 32'(hold_cycles - h0), 6);
      check("t1_we_cycles", 32'(we_cycles - w0), 1);

      // Two words with gaps between bytes
      w0 = we_cycles;
      push_word(8'd0, 16'hAABB);
      push_word(8'd1, 16'hCCDD);
      pulse_start();
      bq = '{8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h10};
      send_q(2);
      wait_done(1'b0);
      check("t2_we_cycles", 32'(we_cycles - w0), 2);

      // Bad checksum; next start clears error
      push_word(8'd0, 16'h1234);
      pulse_start();
      bq = '{8'h01, 8'h12, 8'h34, 8'h48};
      send_q(0);
      wait_done(1'b1);
      pulse_start();
      check("t3_error_cleared_a", 32'(err_a), 0);
      check("t3_error_cleared_b", 32'(err_b), 0);
      check("t3_busy", 32'(busy_a), 1);

      // Three words (wraps on the FE instance) with an ignored mid-session start
      w0 = we_cycles;
      push_word(8'd0, 16'h0001);
      push_word(8'd1, 16'h0002);
      push_word(8'd2, 16'h0003);
      bq = '{8'h03, 8'h00, 8'h01};
      send_q(0);
      pulse_start();
      check("t4_busy_mid", 32'(busy_a), 1);
      bq = '{8'h00, 8'h02, 8'h00, 8'h03, 8'h09};
      send_q(0);
      wait_done(1'b0);
      @(negedge clk);
      check("t4_still_idle", 32'(busy_a), 0);
      check("t4_we_cycles", 32'(we_cycles - w0), 3);

      // Reset in the middle of word 0
      w0 = we_cycles;
      pulse_start();
      bq = '{8'h01, 8'h12};
      send_q(0);
      rst = 1'b1;
      #1;
      check("t5_hold", 32'(hold_a), 0);
      check("t5_busy", 32'(busy_a), 0);
      check("t5_rx_ready", 32'(rx_ready_a), 0);
      check("t5_we", 32'(we_a), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("t5_no_write", 32'(we_cycles - w0), 0);
      push_word(8'd0, 16'h1234);
      pulse_start();
      bq = '{8'h01, 8'h12, 8'h34, 8'h47};
      send_q(0);
      wait_done(1'b0);

      // N = 0 means a full 256-word image
      w0 = we_cycles;
      bq = '{8'h00};
      sum = 8'h00;
      for (int i = 0; i < 256; i++) begin
         bq.push_back(8'h00);
         bq.push_back(8'(i));
         push_word(8'(i), {8'h00, 8'(i)});
         sum = sum + 8'(i);
      end
      bq.push_back(sum);
      pulse_start();
      send_q(0);
      wait_done(1'b0);
      check("t6_we_cycles", 32'(we_cycles - w0), 256);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
